// File: rtl/rotation_pkg.sv
// Shared types for the rotator checker: lane triple, monitor states and the
// reference rotation (f,g,h) -> (h,f,g).
package rotation_pkg;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] f;
        logic [W-1:0] g;
        logic [W-1:0] h;
    } triple_t;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCKED
    } mon_state_t;

    function automatic triple_t rotate(input triple_t t);
        triple_t r;
        r.f = t.h;
        r.g = t.f;
        r.h = t.g;
        return r;
    endfunction

endpackage

// File: rtl/rotation_monitor_if.sv
// Sample/control bundle between the rotator side (master) and the monitor (slave).
interface rotation_monitor_if #(
    parameter int unsigned ERR_W = 8
);
    import rotation_pkg::*;

    logic               dut_reset;
    logic               in_valid;
    logic [W-1:0]       in_f;
    logic [W-1:0]       in_g;
    logic [W-1:0]       in_h;
    logic               clr_err;
    logic               locked;
    logic               err_pulse;
    logic [2:0]         err_lanes;
    logic [ERR_W-1:0]   err_count;
    logic               home_hit;

    modport master (
        output dut_reset, in_valid, in_f, in_g, in_h, clr_err,
        input  locked, err_pulse, err_lanes, err_count, home_hit
    );

    modport slave (
        input  dut_reset, in_valid, in_f, in_g, in_h, clr_err,
        output locked, err_pulse, err_lanes, err_count, home_hit
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coincident with an
// increment leaves the count at 1 so the new event is not lost.
module sat_counter #(
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [ERR_W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? ERR_W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + ERR_W'(1);
        end
    end

endmodule

// File: rtl/rotation_monitor.sv
// Checks that the 3-lane rotator advances (f,g,h) -> (h,f,g) each valid sample,
// locks after LOCK_MATCHES good rotations and counts errors seen while locked.
module rotation_monitor
    import rotation_pkg::*;
#(
    parameter int unsigned LOCK_MATCHES = 2,
    parameter int unsigned ERR_W        = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    rotation_monitor_if.slave  bus
);

    localparam int unsigned CNT_W = (LOCK_MATCHES < 2) ? 1 : $clog2(LOCK_MATCHES + 1);

    mon_state_t       state;
    triple_t          prev;
    triple_t          home;
    triple_t          sample_c;
    triple_t          exp_c;
    logic [CNT_W-1:0] match_cnt;
    logic [2:0]       diff_c;
    logic             match_c;
    logic             err_c;
    logic             locked_q;
    logic             err_pulse_q;
    logic             home_hit_q;
    logic [2:0]       err_lanes_q;
    logic [ERR_W-1:0] err_count_q;

    assign sample_c = {bus.in_f, bus.in_g, bus.in_h};
    assign exp_c    = rotate(prev);
    assign diff_c   = {sample_c.f != exp_c.f, sample_c.g != exp_c.g, sample_c.h != exp_c.h};
    assign match_c  = (diff_c == 3'b000);
    assign err_c    = bus.in_valid && !bus.dut_reset && (state == LOCKED) && !match_c;

    // Rotator reset takes priority over any sample; pulses default low every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            prev        <= '0;
            home        <= '0;
            match_cnt   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            home_hit_q  <= 1'b0;
            err_lanes_q <= 3'b000;
        end else begin
            err_pulse_q <= 1'b0;
            home_hit_q  <= 1'b0;
            if (bus.dut_reset) begin
                state     <= IDLE;
                locked_q  <= 1'b0;
                match_cnt <= '0;
            end else if (bus.in_valid) begin
                prev <= sample_c;
                case (state)
                    IDLE: begin
                        match_cnt <= '0;
                        state     <= ACQ;
                    end
                    ACQ: begin
                        if (!match_c) begin
                            match_cnt <= '0;
                        end else if (match_cnt == CNT_W'(LOCK_MATCHES - 1)) begin
                            match_cnt <= '0;
                            home      <= sample_c;
                            locked_q  <= 1'b1;
                            state     <= LOCKED;
                        end else begin
                            match_cnt <= match_cnt + CNT_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (match_c) begin
                            home_hit_q <= (sample_c == home);
                        end else begin
                            err_pulse_q <= 1'b1;
                            err_lanes_q <= diff_c;
                            locked_q    <= 1'b0;
                            match_cnt   <= '0;
                            state       <= ACQ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    sat_counter #(.ERR_W(ERR_W)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (err_c),
        .clr     (bus.clr_err),
        .count   (err_count_q)
    );

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.home_hit  = home_hit_q;
    assign bus.err_lanes = err_lanes_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_rotation_monitor.sv
// Directed bench for rotation_monitor: lock, error, rotator reset, clear/saturation,
// valid gaps and asynchronous reset.
module tb_rotation_monitor;
    import rotation_pkg::*;

    logic    clk = 1'b0;
    logic    reset_n = 1'b0;
    int      tests = 0;
    int      fails = 0;
    triple_t last = '0;

    rotation_monitor_if #(.ERR_W(8)) bus ();

    rotation_monitor #(.LOCK_MATCHES(2), .ERR_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic triple_t nxt(input triple_t t);
        triple_t r;
        r = {t.h, t.f, t.g};
        return r;
    endfunction

    task automatic send(input logic [3:0] f, input logic [3:0] g, input logic [3:0] h);
        bus.in_valid = 1'b1;
        bus.in_f = f;
        bus.in_g = g;
        bus.in_h = h;
        @(posedge clk);
        #1;
        last = {f, g, h};
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_next();
        triple_t t;
        t = nxt(last);
        send(t.f, t.g, t.h);
    endtask

    task automatic inject_error();
        triple_t t;
        t = nxt(last);
        send(t.f, t.g, t.h ^ 4'h1);
    endtask

    task automatic relock();
        send_next();
        send_next();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({bus.locked, bus.err_pulse, bus.home_hit, bus.err_lanes, bus.err_count} !== 14'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {bus.locked, bus.err_pulse, bus.home_hit, bus.err_lanes, bus.err_count});
        end
        tests++;
        if (dut.state !== IDLE) begin
            fails++;
            $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE);
        end
        reset_n = 1'b1;
        repeat (3) idle();
        tests++;
        if ({bus.locked, bus.err_pulse, bus.home_hit, bus.err_lanes, bus.err_count} !== 14'd0) begin
            fails++;
            $display("FAIL idle_outputs got=%h exp=0",
                     {bus.locked, bus.err_pulse, bus.home_hit, bus.err_lanes, bus.err_count});
        end
    endtask

    task automatic test_lock();
        logic [3:0] exp_lock [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       exp_hit  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        triple_t    seq      [6] = '{{4'h5, 4'h8, 4'hC}, {4'hC, 4'h5, 4'h8}, {4'h8, 4'hC, 4'h5},
                                     {4'h5, 4'h8, 4'hC}, {4'hC, 4'h5, 4'h8}, {4'h8, 4'hC, 4'h5}};
        for (int i = 0; i < 6; i++) begin
            send(seq[i].f, seq[i].g, seq[i].h);
            tests++;
            if ({bus.locked, bus.home_hit, bus.err_pulse} !== {exp_lock[i][0], exp_hit[i], 1'b0}) begin
                fails++;
                $display("FAIL lock_seq[%0d] got lock/hit/err=%b exp=%b", i,
                         {bus.locked, bus.home_hit, bus.err_pulse}, {exp_lock[i][0], exp_hit[i], 1'b0});
            end
        end
        send(4'h5, 4'h8, 4'hC);
    endtask

    task automatic test_error();
        send(4'hC, 4'h5, 4'h9);
        tests++;
        if ({bus.err_pulse, bus.err_lanes, bus.err_count, bus.locked} !== {1'b1, 3'b001, 8'd1, 1'b0}) begin
            fails++;
            $display("FAIL error_detect got pulse=%b lanes=%b cnt=%0d lock=%b exp 1 001 1 0",
                     bus.err_pulse, bus.err_lanes, bus.err_count, bus.locked);
        end
        idle();
        tests++;
        if ({bus.err_pulse, bus.err_lanes} !== {1'b0, 3'b001}) begin
            fails++;
            $display("FAIL error_pulse_width got pulse=%b lanes=%b exp 0 001", bus.err_pulse, bus.err_lanes);
        end
        send(4'h9, 4'hC, 4'h5);
        send(4'h5, 4'h9, 4'hC);
        tests++;
        if ({bus.locked, bus.err_pulse, bus.err_count} !== {1'b1, 1'b0, 8'd1}) begin
            fails++;
            $display("FAIL error_relock got lock=%b pulse=%b cnt=%0d exp 1 0 1",
                     bus.locked, bus.err_pulse, bus.err_count);
        end
    endtask

    task automatic test_dut_reset();
        bus.dut_reset = 1'b1;
        send(4'h0, 4'h0, 4'h0);
        bus.dut_reset = 1'b0;
        tests++;
        if ({bus.locked, bus.err_pulse, bus.err_count} !== {1'b0, 1'b0, 8'd1} || dut.state !== IDLE) begin
            fails++;
            $display("FAIL dut_reset got lock=%b pulse=%b cnt=%0d state=%0d exp 0 0 1 IDLE",
                     bus.locked, bus.err_pulse, bus.err_count, dut.state);
        end
        send(4'h5, 4'h8, 4'hC);
        send(4'hC, 4'h5, 4'h8);
        tests++;
        if (bus.locked !== 1'b0) begin
            fails++;
            $display("FAIL dut_reset_early_lock got=%b exp=0", bus.locked);
        end
        send(4'h8, 4'hC, 4'h5);
        tests++;
        if ({bus.locked, bus.err_pulse, bus.err_count} !== {1'b1, 1'b0, 8'd1}) begin
            fails++;
            $display("FAIL dut_reset_relock got lock=%b pulse=%b cnt=%0d exp 1 0 1",
                     bus.locked, bus.err_pulse, bus.err_count);
        end
    endtask

    task automatic test_clr_sat();
        repeat (6) begin
            inject_error();
            relock();
        end
        tests++;
        if (bus.err_count !== 8'd7) begin
            fails++;
            $display("FAIL count_to_7 got=%0d exp=7", bus.err_count);
        end
        bus.clr_err = 1'b1;
        inject_error();
        bus.clr_err = 1'b0;
        tests++;
        if ({bus.err_pulse, bus.err_count} !== {1'b1, 8'd1}) begin
            fails++;
            $display("FAIL clr_with_error got pulse=%b cnt=%0d exp 1 1", bus.err_pulse, bus.err_count);
        end
        relock();
        bus.clr_err = 1'b1;
        idle();
        bus.clr_err = 1'b0;
        tests++;
        if (bus.err_count !== 8'd0) begin
            fails++;
            $display("FAIL clr_alone got=%0d exp=0", bus.err_count);
        end
        repeat (300) begin
            inject_error();
            relock();
        end
        tests++;
        if (bus.err_count !== 8'd255) begin
            fails++;
            $display("FAIL saturate got=%0d exp=255", bus.err_count);
        end
        inject_error();
        tests++;
        if ({bus.err_pulse, bus.err_lanes, bus.err_count, bus.locked} !== {1'b1, 3'b001, 8'd255, 1'b0}) begin
            fails++;
            $display("FAIL saturate_hold got pulse=%b lanes=%b cnt=%0d lock=%b exp 1 001 255 0",
                     bus.err_pulse, bus.err_lanes, bus.err_count, bus.locked);
        end
        relock();
    endtask

    task automatic test_gaps();
        int hits = 0;
        for (int i = 0; i < 6; i++) begin
            send_next();
            if (bus.home_hit === 1'b1) hits++;
            tests++;
            if ({bus.locked, bus.err_pulse} !== 2'b10) begin
                fails++;
                $display("FAIL gap_sample[%0d] got lock/err=%b exp=10", i, {bus.locked, bus.err_pulse});
            end
            idle();
            idle();
            tests++;
            if ({bus.locked, bus.err_pulse, bus.home_hit} !== 3'b100) begin
                fails++;
                $display("FAIL gap_idle[%0d] got lock/err/hit=%b exp=100", i,
                         {bus.locked, bus.err_pulse, bus.home_hit});
            end
        end
        tests++;
        if (hits !== 2) begin
            fails++;
            $display("FAIL gap_home_hits got=%0d exp=2", hits);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({bus.locked, bus.err_pulse, bus.home_hit, bus.err_lanes, bus.err_count} !== 14'd0) begin
            fails++;
            $display("FAIL async_reset got=%h exp=0",
                     {bus.locked, bus.err_pulse, bus.home_hit, bus.err_lanes, bus.err_count});
        end
        reset_n = 1'b1;
    endtask

    initial begin
        bus.dut_reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_f      = '0;
        bus.in_g      = '0;
        bus.in_h      = '0;
        bus.clr_err   = 1'b0;
        test_reset();
        test_lock();
        test_error();
        test_dut_reset();
        test_clr_sat();
        test_gaps();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
